// File: rtl/config_sequencer.sv
// config_sequencer
//
// Buffers 32-bit configuration words in a small FIFO. Each group of three words
// is replayed to the configuration latch loader as register writes to 0x08
// (bits 31:0), 0x0C (bits 63:32) and 0x10 (bits 79:64, which commits the frame).
// No write is issued while the loader reports busy.
//
// Ports:
//   clk, rst     - single rising-edge clock, synchronous active-high reset
//   start        - one-cycle pulse arming a session of NUM_FRAMES frames
//   s_valid      - input word valid
//   s_data       - input word
//   s_ready      - FIFO can accept (not full)
//   busy_in      - loader busy flag
//   write_req    - registered one-cycle write strobe to the loader
//   address      - registered write address (0x08 / 0x0C / 0x10)
//   data_out     - registered write data
//   active       - session in progress
//   done         - one-cycle pulse when the session completes
//   frames_done  - frames committed in the current or last session
module config_sequencer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned NUM_FRAMES = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            s_valid,
    input  logic [31:0]                     s_data,
    output logic                            s_ready,
    input  logic                            busy_in,
    output logic                            write_req,
    output logic [5:0]                      address,
    output logic [31:0]                     data_out,
    output logic                            active,
    output logic                            done,
    output logic [$clog2(NUM_FRAMES+1)-1:0] frames_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = $clog2(NUM_FRAMES + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_FRAMES);

    typedef enum logic [2:0] {
        StIdle,
        StW0,
        StW1,
        StW2,
        StHold,
        StWaitBusy
    } state_e;

    state_e state_q, state_d;

    // FIFO storage and bookkeeping
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop, empty;
    logic [31:0]   head;

    // Registered loader-side outputs
    logic          write_req_q;
    logic [5:0]    address_q;
    logic [31:0]   data_q;
    logic          done_q;
    logic [FW-1:0] frames_done_q;

    // Next-state decode results
    logic          issue;
    logic [5:0]    issue_addr;
    logic [31:0]   issue_data;
    logic          frames_clr, frames_inc, done_d;

    assign empty   = (count_q == '0);
    assign s_ready = (count_q != FULL_CNT);
    assign push    = s_valid && s_ready;
    assign pop     = issue;
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        issue_addr = 6'h08;
        issue_data = head;
        frames_clr = 1'b0;
        frames_inc = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StW0;
                    frames_clr = 1'b1;
                end
            end
            StW0: begin
                if (!empty && !busy_in) begin
                    issue   = 1'b1;
                    state_d = StW1;
                end
            end
            StW1: begin
                issue_addr = 6'h0C;
                if (!empty && !busy_in) begin
                    issue   = 1'b1;
                    state_d = StW2;
                end
            end
            StW2: begin
                // Commit word carries only bits 79:64 of the frame.
                issue_addr = 6'h10;
                issue_data = {16'h0000, head[15:0]};
                if (!empty && !busy_in) begin
                    issue   = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                // Loader raises busy one cycle late, so busy_in is not trusted here.
                frames_inc = 1'b1;
                state_d    = StWaitBusy;
            end
            StWaitBusy: begin
                if (!busy_in) begin
                    if (frames_done_q == LAST_FRAME) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StW0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            write_req_q   <= 1'b0;
            address_q     <= '0;
            data_q        <= '0;
            done_q        <= 1'b0;
            frames_done_q <= '0;
        end else begin
            state_q     <= state_d;
            write_req_q <= issue;
            done_q      <= done_d;
            if (issue) begin
                address_q <= issue_addr;
                data_q    <= issue_data;
            end
            if (frames_clr) begin
                frames_done_q <= '0;
            end else if (frames_inc && (frames_done_q != LAST_FRAME)) begin
                frames_done_q <= frames_done_q + 1'b1;
            end
        end
    end

    assign write_req   = write_req_q;
    assign address     = address_q;
    assign data_out    = data_q;
    assign done        = done_q;
    assign frames_done = frames_done_q;
    assign active      = (state_q != StIdle);

endmodule

// File: tb/tb_config_sequencer.sv
`timescale 1ns/1ps
// Bench for config_sequencer: an eight-frame instance for most scenarios and a
// one-frame instance for the single-frame session.
module tb_config_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned NF    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // eight-frame instance
    logic        start, s_valid, busy_in;
    logic [31:0] s_data;
    logic        s_ready, write_req, active, done;
    logic [5:0]  address;
    logic [31:0] data_out;
    logic [3:0]  frames_done;
    // one-frame instance
    logic        start1, s_valid1, busy1;
    logic [31:0] s_data1;
    logic        s_ready1, write_req1, active1, done1;
    logic [5:0]  address1;
    logic [31:0] data_out1;
    logic [0:0]  frames_done1;

    config_sequencer #(.DEPTH(DEPTH), .NUM_FRAMES(NF)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .busy_in(busy_in), .write_req(write_req), .address(address),
        .data_out(data_out), .active(active), .done(done), .frames_done(frames_done)
    );

    config_sequencer #(.DEPTH(DEPTH), .NUM_FRAMES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .s_valid(s_valid1), .s_data(s_data1),
        .s_ready(s_ready1), .busy_in(busy1), .write_req(write_req1), .address(address1),
        .data_out(data_out1), .active(active1), .done(done1), .frames_done(frames_done1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation of the eight-frame instance: accepted words, issued writes, done pulses.
    logic [31:0] exp_q[$];
    logic [5:0]  obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    int          done_cyc[$];
    int          busy_viol = 0;
    int          done_active_bad = 0;
    logic        busy_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            obs_addr.delete();
            obs_data.delete();
            obs_cyc.delete();
            done_cyc.delete();
            busy_viol       = 0;
            done_active_bad = 0;
        end else begin
            if (s_valid && s_ready) exp_q.push_back(s_data);
            if (write_req === 1'b1) begin
                obs_addr.push_back(address);
                obs_data.push_back(data_out);
                obs_cyc.push_back(cyc);
                if (busy_prev) busy_viol++;
            end
            if (done === 1'b1) begin
                done_cyc.push_back(cyc);
                if (active !== 1'b0) done_active_bad++;
            end
        end
        busy_prev = busy_in;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        start = 1'b0; s_valid = 1'b0; busy_in = 1'b0; s_data = '0;
        start1 = 1'b0; s_valid1 = 1'b0; busy1 = 1'b0; s_data1 = '0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        s_valid = 1'b1;
        s_data  = w;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
        checks++; if (write_req !== 1'b0) begin errors++; $display("FAIL rst_write_req: got %b want 0", write_req); end
        checks++; if (address !== 6'h00) begin errors++; $display("FAIL rst_address: got %h want 00", address); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rst_data_out: got %h want 0", data_out); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b want 0", active); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (frames_done !== 4'd0) begin errors++; $display("FAIL rst_frames_done: got %0d want 0", frames_done); end
        checks++; if (s_ready1 !== 1'b1 || active1 !== 1'b0 || write_req1 !== 1'b0)
            begin errors++; $display("FAIL rst_dut1: ready=%b active=%b wr=%b want 1 0 0", s_ready1, active1, write_req1); end
        @(posedge clk); #1;
        // Words pushed while idle are held, never written.
        push_word(32'hA5A50001);
        push_word(32'hA5A50002);
        push_word(32'hA5A50003);
        repeat (6) tick();
        @(negedge clk);
        checks++; if (obs_addr.size() != 0) begin errors++; $display("FAIL idle_no_write: got %0d writes want 0", obs_addr.size()); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL idle_active: got %b want 0", active); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL idle_s_ready_3words: got %b want 1", s_ready); end
        checks++; if (exp_q.size() != 3) begin errors++; $display("FAIL idle_accepted: got %0d words want 3", exp_q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_fifo_full();
        push_word(32'hA5A50004);
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready: got %b want 0", s_ready); end
        @(posedge clk); #1;
        // Overflow attempt must be refused.
        s_valid = 1'b1; s_data = 32'hDEADBEEF;
        tick(); tick();
        s_valid = 1'b0;
        @(negedge clk);
        checks++; if (exp_q.size() != 4) begin errors++; $display("FAIL full_overflow: got %0d accepted want 4", exp_q.size()); end
        checks++; if (s_ready !== 1'b0 || write_req !== 1'b0)
            begin errors++; $display("FAIL full_hold: ready=%b wr=%b want 0 0", s_ready, write_req); end
        @(posedge clk); #1;
    endtask

    // Eight frames from a full FIFO plus 20 randomly-fed words; loader busy after
    // each commit and random stalls mid-frame.
    task automatic test_session_wrap();
        int n, lcnt, c_commit, l_last, budget;
        lcnt = 0; c_commit = 0; l_last = 0; budget = 0;
        start = 1'b1; n = cyc; tick(); start = 1'b0;
        while (done_cyc.size() == 0 && budget < 3000) begin
            if (lcnt > 0) begin
                busy_in = 1'b1;
                lcnt--;
            end else begin
                busy_in = (obs_addr.size() >= 3) && (obs_addr.size() % 3 != 0) &&
                          ($urandom_range(0, 5) == 0);
            end
            if (write_req === 1'b1 && address == 6'h10) begin
                lcnt = $urandom_range(1, 16);
                l_last = lcnt;
                c_commit = cyc;
            end
            s_valid = (exp_q.size() < 24) && ($urandom_range(0, 1) == 1);
            s_data  = $urandom;
            tick();
            budget++;
        end
        busy_in = 1'b0;
        s_valid = 1'b0;
        checks++; if (done_cyc.size() == 0) begin errors++; $display("FAIL session_done: no done within %0d cycles", budget); end
        checks++; if (obs_addr.size() != 24) begin errors++; $display("FAIL session_count: got %0d writes want 24", obs_addr.size()); end
        checks++; if (exp_q.size() != 24) begin errors++; $display("FAIL session_fed: got %0d words want 24", exp_q.size()); end
        if (obs_cyc.size() >= 3) begin
            checks++; if (obs_cyc[0] != n + 2) begin errors++; $display("FAIL start_latency: write at %0d want %0d", obs_cyc[0], n + 2); end
            checks++; if (obs_cyc[1] != n + 3 || obs_cyc[2] != n + 4)
                begin errors++; $display("FAIL back_to_back: writes at %0d %0d want %0d %0d", obs_cyc[1], obs_cyc[2], n + 3, n + 4); end
        end
        for (int k = 0; k < obs_addr.size() && k < exp_q.size() && k < 24; k++) begin
            logic [5:0]  ea;
            logic [31:0] ed, w;
            w = exp_q[k];
            case (k % 3)
                0:       ea = 6'h08;
                1:       ea = 6'h0C;
                default: ea = 6'h10;
            endcase
            ed = (k % 3 == 2) ? {16'h0000, w[15:0]} : w;
            checks++; if (obs_addr[k] !== ea) begin errors++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, obs_addr[k], ea); end
            checks++; if (obs_data[k] !== ed) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", k, obs_data[k], ed); end
        end
        for (int k = 3; k < obs_cyc.size(); k += 3) begin
            checks++;
            if (obs_cyc[k] - obs_cyc[k - 1] < 3)
                begin errors++; $display("FAIL frame_gap[%0d]: gap %0d want >=3", k, obs_cyc[k] - obs_cyc[k - 1]); end
        end
        checks++; if (busy_viol != 0) begin errors++; $display("FAIL busy_rule: %0d writes after busy, want 0", busy_viol); end
        if (done_cyc.size() > 0) begin
            checks++; if (done_cyc[0] != c_commit + l_last + 2)
                begin errors++; $display("FAIL done_timing: done at %0d want %0d", done_cyc[0], c_commit + l_last + 2); end
        end
        checks++; if (done_active_bad != 0) begin errors++; $display("FAIL done_active: active high with done %0d times want 0", done_active_bad); end
        @(negedge clk);
        checks++; if (frames_done !== 4'd8) begin errors++; $display("FAIL session_frames: got %0d want 8", frames_done); end
        checks++; if (active !== 1'b0 || done !== 1'b0 || done_cyc.size() != 1)
            begin errors++; $display("FAIL session_end: active=%b done=%b pulses=%0d want 0 0 1", active, done, done_cyc.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame();
        int n, c_commit, d_cyc;
        int wc[$];
        logic [5:0]  wa[$];
        logic [31:0] wd[$];
        logic [31:0] words[3];
        logic [5:0]  ea[3];
        logic [31:0] ed[3];
        words = '{32'h11111111, 32'h22222222, 32'hABCD1234};
        ea    = '{6'h08, 6'h0C, 6'h10};
        ed    = '{32'h11111111, 32'h22222222, 32'h00001234};
        do_reset(2);
        for (int i = 0; i < 3; i++) begin
            s_valid1 = 1'b1; s_data1 = words[i]; tick();
        end
        s_valid1 = 1'b0;
        start1 = 1'b1; n = cyc; tick(); start1 = 1'b0;
        c_commit = -100; d_cyc = -1;
        for (int i = 0; i < 60 && d_cyc < 0; i++) begin
            busy1 = (cyc > c_commit) && (cyc <= c_commit + 16);
            @(negedge clk);
            if (write_req1 === 1'b1) begin
                wc.push_back(cyc); wa.push_back(address1); wd.push_back(data_out1);
                if (address1 == 6'h10) c_commit = cyc;
            end
            if (done1 === 1'b1) begin
                d_cyc = cyc;
                checks++; if (active1 !== 1'b0) begin errors++; $display("FAIL single_done_active: active %b want 0", active1); end
            end
            @(posedge clk); #1;
        end
        busy1 = 1'b0;
        checks++; if (d_cyc < 0) begin errors++; $display("FAIL single_done: no done within 60 cycles"); end
        checks++; if (wa.size() != 3) begin errors++; $display("FAIL single_count: got %0d writes want 3", wa.size()); end
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] !== ea[i] || wd[i] !== ed[i] || wc[i] != n + 2 + i)
                begin errors++; $display("FAIL single_write[%0d]: got %h/%h @%0d want %h/%h @%0d",
                                         i, wa[i], wd[i], wc[i], ea[i], ed[i], n + 2 + i); end
        end
        checks++; if (d_cyc != c_commit + 18) begin errors++; $display("FAIL single_done_timing: got %0d want %0d", d_cyc, c_commit + 18); end
        @(negedge clk);
        checks++; if (frames_done1 !== 1'b1 || done1 !== 1'b0)
            begin errors++; $display("FAIL single_frames: frames=%0d done=%b want 1 0", frames_done1, done1); end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_gating();
        int n, bad;
        bad = 0;
        do_reset(2);
        push_word(32'hC0FFEE01);
        start = 1'b1; n = cyc; tick(); start = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (write_req !== 1'b1 || address !== 6'h08 || data_out !== 32'hC0FFEE01)
            begin errors++; $display("FAIL gate_first: %b/%h/%h want 1/08/c0ffee01", write_req, address, data_out); end
        @(posedge clk); #1;
        busy_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin s_valid = 1'b1; s_data = 32'hC0FFEE02; end
            else if (i == 1) s_data = 32'hC0FFEE03;
            else s_valid = 1'b0;
            @(negedge clk);
            if (write_req !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        busy_in = 1'b0;
        @(negedge clk);
        if (write_req !== 1'b0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL busy_gate_window: %0d writes seen want 0", bad); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (write_req !== 1'b1 || address !== 6'h0C || data_out !== 32'hC0FFEE02 || cyc != n + 14)
            begin errors++; $display("FAIL gate_resume: %b/%h/%h @%0d want 1/0c/c0ffee02 @%0d",
                                     write_req, address, data_out, cyc, n + 14); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (write_req !== 1'b1 || address !== 6'h10 || data_out !== 32'h0000EE03)
            begin errors++; $display("FAIL gate_commit: %b/%h/%h want 1/10/0000ee03", write_req, address, data_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_empty_stall();
        int n, p, bad;
        bad = 0;
        do_reset(2);
        push_word(32'h0BADF00D);
        push_word(32'h12345678);
        start = 1'b1; n = cyc; tick(); start = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (write_req !== 1'b1 || address !== 6'h08 || data_out !== 32'h0BADF00D)
            begin errors++; $display("FAIL stall_w0: %b/%h/%h want 1/08/0badf00d", write_req, address, data_out); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (write_req !== 1'b1 || address !== 6'h0C || data_out !== 32'h12345678)
            begin errors++; $display("FAIL stall_w1: %b/%h/%h want 1/0c/12345678", write_req, address, data_out); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (write_req !== 1'b0 || active !== 1'b1) bad++;
        end
        @(posedge clk); #1;
        p = cyc;
        s_valid = 1'b1; s_data = 32'hFEEDBEEF;
        @(negedge clk);
        if (write_req !== 1'b0) bad++;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        if (write_req !== 1'b0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_window: %0d bad cycles want 0", bad); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (write_req !== 1'b1 || address !== 6'h10 || data_out !== 32'h0000BEEF || cyc != p + 2)
            begin errors++; $display("FAIL stall_commit: %b/%h/%h @%0d want 1/10/0000beef @%0d",
                                     write_req, address, data_out, cyc, p + 2); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] fresh[3];
        logic [5:0]  ea[3];
        logic [31:0] w;
        fresh = '{32'h5EED0001, 32'h5EED0002, 32'h5EED7777};
        ea    = '{6'h08, 6'h0C, 6'h10};
        do_reset(2);
        push_word(32'h0D0D0001);
        push_word(32'h0D0D0002);
        push_word(32'h0D0D0003);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (write_req !== 1'b1 || address !== 6'h08)
            begin errors++; $display("FAIL midrst_w0: %b/%h want 1/08", write_req, address); end
        @(posedge clk); #1;
        busy_in = 1'b1;
        @(negedge clk);
        checks++; if (write_req !== 1'b1 || address !== 6'h0C)
            begin errors++; $display("FAIL midrst_w1: %b/%h want 1/0c", write_req, address); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        busy_in = 1'b0;
        @(negedge clk);
        checks++; if (write_req !== 1'b0 || active !== 1'b0 || address !== 6'h00 || data_out !== 32'h0 ||
                      s_ready !== 1'b1 || frames_done !== 4'd0)
            begin errors++; $display("FAIL midrst_state: wr=%b act=%b addr=%h data=%h rdy=%b fr=%0d want 0 0 00 0 1 0",
                                     write_req, active, address, data_out, s_ready, frames_done); end
        repeat (5) begin @(posedge clk); #1; end
        checks++; if (obs_addr.size() != 0) begin errors++; $display("FAIL midrst_no_write: got %0d writes want 0", obs_addr.size()); end
        for (int i = 0; i < 3; i++) push_word(fresh[i]);
        start = 1'b1; tick(); start = 1'b0;
        repeat (8) tick();
        checks++; if (obs_addr.size() != 3) begin errors++; $display("FAIL midrst_fresh_count: got %0d want 3", obs_addr.size()); end
        for (int i = 0; i < 3 && i < obs_addr.size(); i++) begin
            w = fresh[i];
            if (i == 2) w = {16'h0000, w[15:0]};
            checks++;
            if (obs_addr[i] !== ea[i] || obs_data[i] !== w)
                begin errors++; $display("FAIL midrst_fresh[%0d]: got %h/%h want %h/%h", i, obs_addr[i], obs_data[i], ea[i], w); end
        end
    endtask

    initial begin
        test_reset();
        test_fifo_full();
        test_session_wrap();
        test_single_frame();
        test_busy_gating();
        test_empty_stall();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
